// File: rtl/nb_update_ctrl.sv
// Four-register update engine: loads a..d, applies steps rounds of cross-coupled updates, then pulses done.
// Optional stall input enabled by macro NB_UPDATE_CTRL_HOLD_EN (port hold freezes RUN).
module nb_update_ctrl #(
    parameter int WIDTH = 32,
    parameter int SUB_K = 3,
    parameter int ADD_K = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_init,
    input  logic [WIDTH-1:0] b_init,
    input  logic [WIDTH-1:0] c_init,
    input  logic [WIDTH-1:0] d_init,
    input  logic [7:0]       steps,
`ifdef NB_UPDATE_CTRL_HOLD_EN
    input  logic             hold,
`endif
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done,
    output logic [7:0]       step_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] SUB_V = WIDTH'(SUB_K);
    localparam logic [WIDTH-1:0] ADD_V = WIDTH'(ADD_K);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] remaining;
    logic       load_en;
    logic       step_en;
    logic       stall;

`ifdef NB_UPDATE_CTRL_HOLD_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        step_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_en = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = (remaining == 8'd0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (!stall) begin
                    step_en = 1'b1;
                    // remaining is at least 1 here; this step consumes the last one
                    if (remaining == 8'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All four updates read pre-edge values, so the swap-like coupling needs no temporaries.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            remaining <= 8'd0;
            step_idx  <= 8'd0;
        end else if (load_en) begin
            a         <= a_init;
            b         <= b_init;
            c         <= c_init;
            d         <= d_init;
            remaining <= steps;
            step_idx  <= 8'd0;
        end else if (step_en) begin
            a         <= b + c;
            d         <= a - SUB_V;
            b         <= d + ADD_V;
            c         <= c + ONE_V;
            remaining <= remaining - 8'd1;
            step_idx  <= step_idx + 8'd1;
        end
    end

endmodule

// File: tb/tb_nb_update_ctrl.sv
// Randomized bench for nb_update_ctrl: per-cycle compare against a run-sequence model plus literal scenarios.
module tb_nb_update_ctrl;

    localparam logic [1:0] K_IDLE = 2'd0, K_LOAD = 2'd1, K_RUN = 2'd2, K_DONE = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [7:0]  idx;
    } snap_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        hold  = 1'b0;
    logic [31:0] a_init = '0, b_init = '0, c_init = '0, d_init = '0;
    logic [7:0]  steps = '0;
    logic [31:0] a, b, c, d;
    logic        busy, done;
    logic [7:0]  step_idx;

    logic        start8 = 1'b0;
    logic [7:0]  a8_init = '0, b8_init = '0, c8_init = '0, d8_init = '0;
    logic [7:0]  steps8 = '0;
    logic [7:0]  a8, b8, c8, d8;
    logic        busy8, done8;
    logic [7:0]  step_idx8;

    int vectors = 0;
    int errors  = 0;

    snap_t cur = '0;
    snap_t q[$];

    always #5 clock = ~clock;

    nb_update_ctrl dut (
        .clock(clock), .reset(reset), .start(start),
        .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
        .steps(steps),
`ifdef NB_UPDATE_CTRL_HOLD_EN
        .hold(hold),
`endif
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .done(done), .step_idx(step_idx)
    );

    nb_update_ctrl #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8),
        .a_init(a8_init), .b_init(b8_init), .c_init(c8_init), .d_init(d8_init),
        .steps(steps8),
`ifdef NB_UPDATE_CTRL_HOLD_EN
        .hold(1'b0),
`endif
        .a(a8), .b(b8), .c(c8), .d(d8),
        .busy(busy8), .done(done8), .step_idx(step_idx8)
    );

    // Model: on acceptance, precompute the whole sequence of visible cycles of the run.
    task automatic build_run(input logic [31:0] ai, bi, ci, di, input logic [7:0] n);
        snap_t s;
        logic [31:0] na, nb, nc, nd;
        s = '{K_LOAD, ai, bi, ci, di, 8'd0};
        q.push_back(s);
        if (n == 8'd0) begin
            s.kind = K_DONE;
            q.push_back(s);
        end else begin
            s.kind = K_RUN;
            q.push_back(s);
            for (int k = 1; k <= int'(n); k++) begin
                na = s.b + s.c;
                nd = s.a - 32'd3;
                nb = s.d + 32'd10;
                nc = s.c + 32'd1;
                s.a = na; s.b = nb; s.c = nc; s.d = nd;
                s.idx  = 8'(k);
                s.kind = (k == int'(n)) ? K_DONE : K_RUN;
                q.push_back(s);
            end
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            cur <= '0;
        end else if (cur.kind == K_IDLE) begin
            if (start) begin
                build_run(a_init, b_init, c_init, d_init, steps);
                cur <= q.pop_front();
            end
        end else if (cur.kind == K_RUN && hold) begin
            cur <= cur;
        end else if (q.size() > 0) begin
            cur <= q.pop_front();
        end else begin
            cur <= '{K_IDLE, cur.a, cur.b, cur.c, cur.d, cur.idx};
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        chk("model_a", 64'(a), 64'(cur.a));
        chk("model_b", 64'(b), 64'(cur.b));
        chk("model_c", 64'(c), 64'(cur.c));
        chk("model_d", 64'(d), 64'(cur.d));
        chk("model_busy", 64'(busy), 64'(cur.kind == K_LOAD || cur.kind == K_RUN));
        chk("model_done", 64'(done), 64'(cur.kind == K_DONE));
        chk("model_step_idx", 64'(step_idx), 64'(cur.idx));
    endtask

    task automatic do_start(input logic [31:0] ai, bi, ci, di, input logic [7:0] n);
        a_init = ai; b_init = bi; c_init = ci; d_init = di; steps = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Ticks until done; returns the cycle number (LOAD observation is cycle 1).
    task automatic wait_done(output int ncyc);
        ncyc = 1;
        while (!done && ncyc < 60) begin
            tick();
            ncyc++;
        end
        chk("done_within_budget", 64'(done), 64'd1);
    endtask

    initial begin
        int n;
        // reset state
        #1;
        chk("rst_a", 64'(a), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_idx", 64'(step_idx), 64'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // steps=1 from 30/20/15/5
        do_start(32'd30, 32'd20, 32'd15, 32'd5, 8'd1);
        wait_done(n);
        chk("s1_latency", 64'(n), 64'd3);
        chk("s1_a", 64'(a), 64'd35);
        chk("s1_b", 64'(b), 64'd15);
        chk("s1_c", 64'(c), 64'd16);
        chk("s1_d", 64'(d), 64'd27);
        tick();
        chk("s1_done_one_cycle", 64'(done), 64'd0);
        tick();

        // steps=3 from the same init, checking each RUN result
        do_start(32'd30, 32'd20, 32'd15, 32'd5, 8'd3);
        tick(); tick();
        chk("s3_step1", 64'({a[15:0], b[15:0], c[15:0], d[15:0]}), {16'd35, 16'd15, 16'd16, 16'd27});
        tick();
        chk("s3_step2", 64'({a[15:0], b[15:0], c[15:0], d[15:0]}), {16'd31, 16'd37, 16'd17, 16'd32});
        tick();
        chk("s3_step3", 64'({a[15:0], b[15:0], c[15:0], d[15:0]}), {16'd54, 16'd42, 16'd18, 16'd28});
        chk("s3_done", 64'(done), 64'd1);
        chk("s3_idx", 64'(step_idx), 64'd3);
        tick();

        // steps=0: LOAD then DONE
        do_start(32'd1, 32'd2, 32'd3, 32'd4, 8'd0);
        wait_done(n);
        chk("s0_latency", 64'(n), 64'd2);
        chk("s0_vals", 64'({a[15:0], b[15:0], c[15:0], d[15:0]}), {16'd1, 16'd2, 16'd3, 16'd4});
        tick();

        // 8-bit wrap and start pulse during RUN ignored
        a8_init = 8'd0; b8_init = 8'd0; c8_init = 8'd127; d8_init = 8'd0; steps8 = 8'd1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        chk("w8_run_busy", 64'(busy8), 64'd1);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("w8_done", 64'(done8), 64'd1);
        chk("w8_c_wrap", 64'(c8), 64'h80);
        chk("w8_a", 64'(a8), 64'h7f);
        chk("w8_d", 64'(d8), 64'hfd);
        tick();
        chk("w8_no_requeue", 64'(busy8), 64'd0);
        tick();
        chk("w8_no_requeue2", 64'(busy8), 64'd0);

        // reset mid-run at RUN step 2 of 5
        do_start(32'd30, 32'd20, 32'd15, 32'd5, 8'd5);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_vals", 64'({a[15:0], b[15:0], c[15:0], d[15:0]}), 64'd0);
        chk("rst_mid_flags", 64'({busy, done, step_idx}), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_mid_no_done", 64'(done), 64'd0);
        do_start(32'd30, 32'd20, 32'd15, 32'd5, 8'd1);
        wait_done(n);
        chk("rst_rerun_latency", 64'(n), 64'd3);
        chk("rst_rerun_a", 64'(a), 64'd35);
        tick();

`ifdef NB_UPDATE_CTRL_HOLD_EN
        do_start(32'd30, 32'd20, 32'd15, 32'd5, 8'd3);
        tick();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("hold_frozen_busy", 64'(busy), 64'd1);
        chk("hold_frozen_a", 64'(a), 64'd30);
        hold = 1'b0;
        n = 6;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk("hold_latency", 64'(n), 64'd9);
        chk("hold_final_a", 64'(a), 64'd54);
        tick();
`endif

        // randomized runs against the model
        for (int r = 0; r < 60; r++) begin
            int gap, cnt, rst_at;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            do_start($urandom, $urandom, $urandom, $urandom, 8'($urandom_range(0, 10)));
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : -1;
            cnt = 0;
            while (cur.kind != K_IDLE && cnt < 200) begin
                cnt++;
                if (cnt == rst_at) begin
                    start = 1'b0;
                    hold  = 1'b0;
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                end else begin
                    start = ($urandom_range(0, 3) == 0);
`ifdef NB_UPDATE_CTRL_HOLD_EN
                    hold = ($urandom_range(0, 3) == 0);
`endif
                    tick();
                end
            end
            start = 1'b0;
            hold  = 1'b0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
